// File: rtl/inst_line_buffer_pkg.sv
// Shared definitions for the instruction line buffer.
//   NOP          : canonical RV32 no-op (addi x0,x0,0). The core uses the same value.
//   ibuf_state_t : controller states (IDLE lookup, REQ awaiting grant, FILL collecting beats).
package inst_line_buffer_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } ibuf_state_t;

endpackage

// File: rtl/inst_line_buffer_if.sv
// Line-fill bus between the instruction line buffer and the backing ROM/SRAM controller.
//   mem_req    : line-fill request, held until mem_gnt is sampled high
//   mem_addr   : line-aligned fill address
//   mem_gnt    : backing memory accepts the request
//   mem_rvalid : read beat valid
//   mem_rdata  : read beat data, beats arrive in ascending word order
// Modports: master = line buffer side, slave = memory side.
interface inst_line_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/ibuf_line_store.sv
// Storage for one cache line of LINE_WORDS 32-bit instruction words.
//   clk   : clock
//   we    : write strobe (one fill beat)
//   waddr : word index written, driven by the fill beat counter
//   wdata : fill beat data
//   raddr : word index read, driven by the fetch address word field
//   rdata : word at raddr (combinational; the caller registers it)
// The data carries no reset: the valid bit in the controller decides whether
// the contents mean anything.
module ibuf_line_store #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(LINE_WORDS)-1:0] waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(LINE_WORDS)-1:0] raddr,
  output logic [31:0]                   rdata
);

  logic [31:0] words_reg [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      words_reg[waddr] <= wdata;
    end
  end

  assign rdata = words_reg[raddr];

endmodule

// File: rtl/inst_line_buffer.sv
// Instruction-side responder for the RV32E fetch port. Holds one line of
// LINE_WORDS instructions, answers hits with one cycle of registered latency
// and refills the line from backing memory on a miss.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   inst_addr    : fetch address, sampled every rising edge (bits [1:0] ignored)
//   instruction  : registered instruction word (NOP when not ready)
//   inst_ready   : 1 = instruction holds the word for the address sampled on the previous edge
//   flush        : invalidate the line (fence.i / boot-image reload)
//   mem_bus      : line-fill bus (master side)
//   hit_count    : IDLE hit cycles        (only when IBUF_PERF_EN is defined, else 0)
//   miss_count   : IDLE->REQ transitions  (only when IBUF_PERF_EN is defined, else 0)
// Build option: IBUF_PERF_EN enables the two performance counters.
module inst_line_buffer
  import inst_line_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               inst_addr,
  output logic [31:0]               instruction,
  output logic                      inst_ready,
  input  logic                      flush,
  inst_line_buffer_if.master        mem_bus,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 30 - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  ibuf_state_t       state_reg;
  logic              valid_reg;
  logic              flush_pending_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [OFF_W-1:0]  cnt_reg;
  logic              mem_req_reg;
  logic [31:0]       mem_addr_reg;
  logic              inst_ready_reg;
  logic [31:0]       instruction_reg;

  logic [TAG_W-1:0]  addr_tag;
  logic [OFF_W-1:0]  addr_word;
  logic [1:0]        unused_addr_bits;
  logic [31:0]       line_word;
  logic              lookup_hit;
  logic              lookup_miss;
  logic              fill_we;

  assign addr_tag         = inst_addr[31:OFF_W+2];
  assign addr_word        = inst_addr[OFF_W+1:2];
  assign unused_addr_bits = inst_addr[1:0];

  // A flush in IDLE turns what would be a hit into a miss in the same cycle.
  assign lookup_hit  = (state_reg == IDLE) && valid_reg && (tag_reg == addr_tag) && !flush;
  assign lookup_miss = (state_reg == IDLE) && !lookup_hit;
  assign fill_we     = (state_reg == FILL) && mem_bus.mem_rvalid;

  ibuf_line_store #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_store (
    .clk   (clk),
    .we    (fill_we),
    .waddr (cnt_reg),
    .wdata (mem_bus.mem_rdata),
    .raddr (addr_word),
    .rdata (line_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      valid_reg         <= 1'b0;
      flush_pending_reg <= 1'b0;
      tag_reg           <= '0;
      cnt_reg           <= '0;
      mem_req_reg       <= 1'b0;
      mem_addr_reg      <= '0;
      inst_ready_reg    <= 1'b0;
      instruction_reg   <= NOP;
    end else begin
      case (state_reg)
        IDLE: begin
          flush_pending_reg <= 1'b0;
          if (lookup_hit) begin
            instruction_reg <= line_word;
            inst_ready_reg  <= 1'b1;
          end else begin
            instruction_reg <= NOP;
            inst_ready_reg  <= 1'b0;
            mem_req_reg     <= 1'b1;
            mem_addr_reg    <= {addr_tag, {(OFF_W+2){1'b0}}};
            valid_reg       <= 1'b0;
            state_reg       <= REQ;
          end
        end

        REQ: begin
          if (flush) begin
            flush_pending_reg <= 1'b1;
          end
          if (mem_bus.mem_gnt) begin
            mem_req_reg <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= FILL;
          end
        end

        FILL: begin
          if (flush) begin
            flush_pending_reg <= 1'b1;
          end
          if (mem_bus.mem_rvalid) begin
            cnt_reg <= cnt_reg + OFF_W'(1);
            if (cnt_reg == LAST_BEAT) begin
              // The tag comes from the request address, not the current fetch
              // address, which may have moved on while the fill was running.
              tag_reg   <= mem_addr_reg[31:OFF_W+2];
              valid_reg <= !(flush_pending_reg || flush);
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign instruction      = instruction_reg;
  assign inst_ready       = inst_ready_reg;
  assign mem_bus.mem_req  = mem_req_reg;
  assign mem_bus.mem_addr = mem_addr_reg;

`ifdef IBUF_PERF_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (lookup_hit) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (lookup_miss) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`else
  logic unused_lookup_miss;
  assign unused_lookup_miss = lookup_miss;
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
